// File: rtl/fetch_stage.sv
// Dual-issue instruction fetch stage: drives a synchronous two-word ROM and
// registers the returned pair for decode, with stall hold and redirect flush.

module fetch_slot #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              kill,
    input  logic [DATA_W-1:0] instr_d,
    input  logic              vld_d,
    output logic [DATA_W-1:0] instr_q,
    output logic              vld_q
);
    // Kill only drops the valid bit; the stale instruction word is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= '0;
            vld_q   <= 1'b0;
        end else if (kill) begin
            vld_q   <= 1'b0;
        end else if (load) begin
            instr_q <= instr_d;
            vld_q   <= vld_d;
        end
    end
endmodule

module fetch_stage #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_instr1,
    input  logic [DATA_W-1:0] rom_instr2,
    output logic [ADDR_W-1:0] if_pc,
    output logic [DATA_W-1:0] if_instr1,
    output logic [DATA_W-1:0] if_instr2,
    output logic              if_valid1,
    output logic              if_valid2,
    output logic [15:0]       fetch_count
);
    localparam int NUM_SLOTS = 2;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_W-1:0] WRAP_AT   = LAST_ADDR - ADDR_W'(1);

    logic [ADDR_W-1:0] pc, pc_f;
    logic              f_valid;
    logic              load;

    logic [NUM_SLOTS-1:0][DATA_W-1:0] rom_pair;
    logic [NUM_SLOTS-1:0][DATA_W-1:0] slot_instr;
    logic [NUM_SLOTS-1:0]             slot_vld_d;
    logic [NUM_SLOTS-1:0]             slot_vld_q;

    // Pairs never straddle the top of the address space: restart at 0.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return (a >= WRAP_AT) ? '0 : a + ADDR_W'(2);
    endfunction

    assign load = !redirect && !stall;

    // Stall re-presents pc_f so the ROM keeps returning the in-flight pair.
    always_comb begin
        rom_addr = pc;
        if (redirect)
            rom_addr = redirect_addr;
        else if (stall)
            rom_addr = pc_f;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= '0;
            pc_f        <= '0;
            f_valid     <= 1'b0;
            if_pc       <= '0;
            fetch_count <= '0;
        end else if (redirect) begin
            pc_f    <= redirect_addr;
            f_valid <= 1'b1;
            pc      <= next_addr(redirect_addr);
        end else if (!stall) begin
            pc_f    <= pc;
            f_valid <= 1'b1;
            pc      <= next_addr(pc);
            if_pc   <= pc_f;
            if (f_valid)
                fetch_count <= fetch_count + 16'd1;
        end
    end

    assign rom_pair   = {rom_instr2, rom_instr1};
    assign slot_vld_d = {f_valid && (pc_f != LAST_ADDR), f_valid};

    generate
        for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
            fetch_slot #(.DATA_W(DATA_W)) u_slot (
                .clk     (clk),
                .rst_n   (rst_n),
                .load    (load),
                .kill    (redirect),
                .instr_d (rom_pair[s]),
                .vld_d   (slot_vld_d[s]),
                .instr_q (slot_instr[s]),
                .vld_q   (slot_vld_q[s])
            );
        end
    endgenerate

    assign if_instr1 = slot_instr[0];
    assign if_instr2 = slot_instr[1];
    assign if_valid1 = slot_vld_q[0];
    assign if_valid2 = slot_vld_q[1];
endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed stall/redirect/wrap/reset sequences
// push expected pairs; a negedge monitor pops and compares each delivered pair.

module tb_fetch_stage;
    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [9:0]  redirect_addr;
    logic [9:0]  rom_addr;
    logic [9:0]  rom_addr_p1;
    logic [31:0] rom_instr1, rom_instr2;
    logic [9:0]  if_pc;
    logic [31:0] if_instr1, if_instr2;
    logic        if_valid1, if_valid2;
    logic [15:0] fetch_count;

    typedef struct {
        logic [9:0]  pc;
        logic [31:0] i1;
        logic [31:0] i2;
        logic        v2;
        logic [15:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] tb_cnt = 0;
    logic        load_q = 1'b0;

    fetch_stage #(.ADDR_W(10), .DATA_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .rom_addr      (rom_addr),
        .rom_instr1    (rom_instr1),
        .rom_instr2    (rom_instr2),
        .if_pc         (if_pc),
        .if_instr1     (if_instr1),
        .if_instr2     (if_instr2),
        .if_valid1     (if_valid1),
        .if_valid2     (if_valid2),
        .fetch_count   (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [9:0] a);
        return {8'hA5, 6'd0, a, 8'h3C ^ a[7:0]};
    endfunction

    // Synchronous ROM: word[a] and word[a+1] (10-bit wrap) one edge later.
    assign rom_addr_p1 = rom_addr + 10'd1;
    always @(posedge clk) begin
        rom_instr1 <= rom_word(rom_addr);
        rom_instr2 <= rom_word(rom_addr_p1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [9:0] pc, input logic v2);
        exp_t       e;
        logic [9:0] pc1;
        pc1    = pc + 10'd1;
        tb_cnt = tb_cnt + 16'd1;
        e.pc   = pc;
        e.i1   = rom_word(pc);
        e.i2   = rom_word(pc1);
        e.v2   = v2;
        e.cnt  = tb_cnt;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // A new pair is presented after an edge where neither stall nor redirect was set.
    always @(posedge clk) load_q <= rst_n && !stall && !redirect;

    always @(negedge clk) begin
        exp_t e;
        chk("slot2_without_slot1", {63'd0, if_valid2 & ~if_valid1}, 64'd0);
        if (load_q && if_valid1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pair_pc", {54'd0, if_pc}, 64'h3FF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("pair_pc",    {54'd0, if_pc},       {54'd0, e.pc});
                chk("pair_instr1",{32'd0, if_instr1},   {32'd0, e.i1});
                chk("pair_valid2",{63'd0, if_valid2},   {63'd0, e.v2});
                if (e.v2)
                    chk("pair_instr2", {32'd0, if_instr2}, {32'd0, e.i2});
                chk("pair_count", {48'd0, fetch_count}, {48'd0, e.cnt});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_addr = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_if_pc",    {54'd0, if_pc},       64'd0);
        chk("rst_instr1",   {32'd0, if_instr1},   64'd0);
        chk("rst_instr2",   {32'd0, if_instr2},   64'd0);
        chk("rst_valid1",   {63'd0, if_valid1},   64'd0);
        chk("rst_valid2",   {63'd0, if_valid2},   64'd0);
        chk("rst_count",    {48'd0, fetch_count}, 64'd0);
        chk("rst_rom_addr", {54'd0, rom_addr},    64'd0);
        tick(); tick();
        rst_n = 1'b1;

        // Startup: pairs 0, 2, 4
        push(10'd0, 1'b1); push(10'd2, 1'b1); push(10'd4, 1'b1);
        tick();
        chk("start_rom_addr", {54'd0, rom_addr},  64'd2);
        chk("start_bubble",   {63'd0, if_valid1}, 64'd0);
        tick(); tick(); tick();

        // Stall three cycles with if_pc=4, pc_f=6
        stall = 1'b1;
        #1 chk("stall_rom_addr", {54'd0, rom_addr}, 64'd6);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_if_pc",    {54'd0, if_pc},       64'd4);
            chk("stall_count",    {48'd0, fetch_count}, 64'd3);
            chk("stall_rom_addr", {54'd0, rom_addr},    64'd6);
        end
        stall = 1'b0;
        push(10'd6, 1'b1); push(10'd8, 1'b1);
        tick(); tick();

        // Redirect to 0x101: one bubble, then 0x101, 0x103
        redirect = 1'b1; redirect_addr = 10'h101;
        push(10'h101, 1'b1); push(10'h103, 1'b1);
        tick();
        redirect = 1'b0;
        chk("redir_valid1", {63'd0, if_valid1}, 64'd0);
        chk("redir_valid2", {63'd0, if_valid2}, 64'd0);
        chk("redir_pc_hold",{54'd0, if_pc},     64'd8);
        tick(); tick();

        // Redirect and stall together: redirect wins
        redirect = 1'b1; stall = 1'b1; redirect_addr = 10'h200;
        push(10'h200, 1'b1);
        tick();
        redirect = 1'b0; stall = 1'b0;
        chk("redir_stall_valid1", {63'd0, if_valid1}, 64'd0);
        tick();

        // Sequential fetch across the top of memory
        redirect = 1'b1; redirect_addr = 10'd1018;
        push(10'd1018, 1'b1); push(10'd1020, 1'b1); push(10'd1022, 1'b1); push(10'd0, 1'b1);
        tick();
        redirect = 1'b0;
        tick(); tick(); tick(); tick();

        // Odd redirect to the last word: slot 2 invalid, then address 0
        redirect = 1'b1; redirect_addr = 10'd1023;
        push(10'd1023, 1'b0); push(10'd0, 1'b1);
        tick();
        redirect = 1'b0;
        tick(); tick();

        // Reset pulse between edges during a stall
        stall = 1'b1;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_if_pc",    {54'd0, if_pc},       64'd0);
        chk("midrst_instr1",   {32'd0, if_instr1},   64'd0);
        chk("midrst_valid1",   {63'd0, if_valid1},   64'd0);
        chk("midrst_valid2",   {63'd0, if_valid2},   64'd0);
        chk("midrst_count",    {48'd0, fetch_count}, 64'd0);
        chk("midrst_rom_addr", {54'd0, rom_addr},    64'd0);
        rst_n = 1'b1; stall = 1'b0;
        tb_cnt = 16'd0;
        push(10'd0, 1'b1); push(10'd2, 1'b1);
        tick();
        chk("restart_bubble", {63'd0, if_valid1}, 64'd0);
        tick(); tick();
        stall = 1'b1;
        tick(); tick();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        chk("final_count",   {48'd0, fetch_count}, 64'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL expose parameters (name, default, meaning): ADDR_W, 10, instruction-word address width; DATA_W, 32, instruction width.
REQ-002 The block SHALL expose the following ports (name, direction, width, meaning), clock and reset first:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  decode cannot accept; hold fetch.
- redirect  in  1  branch/jump taken; refetch from redirect_addr.
- redirect_addr  in  ADDR_W  redirect target word address (any value, odd allowed).
- rom_addr  out  ADDR_W  address to synchronous ROM; ROM returns word[a] on rom_instr1 and word[a+1] on rom_instr2 one edge later.
- rom_instr1  in  DATA_W  ROM slot-1 data.
- rom_instr2  in  DATA_W  ROM slot-2 data.
- if_pc  out  ADDR_W  address of if_instr1.
- if_instr1  out  DATA_W  registered slot-1 instruction to decode.
- if_instr2  out  DATA_W  registered slot-2 instruction (address if_pc+1).
- if_valid1  out  1  slot 1 holds a live instruction.
- if_valid2  out  1  slot 2 holds a live instruction.
- fetch_count  out  16  number of pairs delivered with if_valid1=1; wraps modulo 2^16.

Function
REQ-003 Internal state SHALL be: pc (next address to issue), pc_f (address in flight in ROM), f_valid (in-flight fetch live), output register set, fetch_count.
REQ-004 rom_addr SHALL be combinational: redirect=1 -> redirect_addr; else stall=1 -> pc_f; else pc.
REQ-005 Next-address rule: after issuing address a, pc SHALL become 0 if a >= 1022, else a+2 (no wrap into high addresses).
REQ-006 Normal cycle (redirect=0, stall=0): pc_f<=pc, f_valid<=1, pc<=next(pc); output regs <= {pc_f, rom_instr1, rom_instr2}; if_valid1<=f_valid; if_valid2<=f_valid and pc_f!=1023.
REQ-007 Stall cycle (redirect=0, stall=1): pc, pc_f, f_valid, all outputs and fetch_count SHALL hold; ROM re-reads pc_f so in-flight data survives the stall.
REQ-008 Redirect cycle (redirect=1, any stall): pc_f<=redirect_addr, f_valid<=1, pc<=next(redirect_addr); if_valid1 and if_valid2 <=0; if_pc/if_instr hold; in-flight data is discarded. Redirect SHALL take priority over stall.
REQ-009 Latency: address issued on rom_addr at edge N appears on if_* outputs after edge N+1 (two edges from issue); redirect penalty SHALL be exactly one bubble cycle.
REQ-010 Throughput SHALL be one pair per cycle with no stall or redirect.
REQ-011 fetch_count SHALL increment on each edge where the output register loads with f_valid=1 (REQ-006 only).
REQ-012 if_valid2 SHALL never be 1 when if_valid1 is 0.
REQ-013 Slot 2 of a pair at address 1023 SHALL be invalid; the next issued address SHALL be 0.

Reset
REQ-014 rst_n=0 SHALL immediately clear pc, pc_f, f_valid, if_pc, if_instr1, if_instr2, if_valid1, if_valid2 and fetch_count to 0, regardless of clock; rom_addr SHALL then read 0 (absent redirect).
REQ-015 Reset asserted mid-stall or mid-redirect SHALL discard all in-flight state; after release, first valid pair (if_pc=0) SHALL appear after the second rising edge.

Verification
REQ-016 Reset release, stall=0, redirect=0 -> edge 1: rom_addr 0->2, if_valid1=0; edge 2: if_pc=0, if_instr1=ROM[0], if_instr2=ROM[1], both valid; edge 3: if_pc=2; fetch_count=1 then 2.
REQ-017 stall=1 for 3 cycles while if_pc=4 -> outputs, fetch_count and pc frozen, rom_addr=pc_f=6; after release, if_pc=6 with ROM[6]/ROM[7], no pair lost or duplicated.
REQ-018 redirect=1, redirect_addr=0x101 for one cycle -> next edge if_valid1=if_valid2=0; following edge if_pc=0x101, if_instr1=ROM[0x101], if_instr2=ROM[0x102]; subsequent if_pc=0x103.
REQ-019 redirect and stall both 1 -> redirect honoured per REQ-008; outputs invalid next edge.
REQ-020 Sequential fetch through 1020, 1022 -> next if_pc=0, both slots valid; redirect to 1023 -> if_pc=1023, if_valid1=1, if_valid2=0, next if_pc=0.
REQ-021 rst_n pulsed low between edges during stall -> all outputs 0 immediately, fetch restarts at address 0 per REQ-015.
